steer_unit: RTL
===============

# steer_unit

Parametrised operand steering stage. It accepts two DATA_W-bit operands per beat and splits them into LANE_W-bit lanes. It routes the lanes to a flattened bank of 2*DATA_W/LANE_W output lanes according to a per-beat mode, and presents the result one cycle later through a valid/ready handshake. It is the next-generation steering block that feeds the reconfigurable multiplier array. It adds generic widths, extra modes, a rotating mode with internal state, backpressure and illegal-mode flagging.

## Interface
- DATA_W, 32, operand width; must be a multiple of LANE_W and at least 2*LANE_W
- LANE_W, 8, lane width
- NLANE, 2*DATA_W/LANE_W (derived localparam, not overridable), number of output lanes
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global enable; when low, the block accepts nothing and holds its output
- select  in  3  mode, sampled with the input beat
- R1  in  DATA_W  operand A
- R2  in  DATA_W  operand B
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- out_data  out  2*DATA_W  steered lanes; lane i occupies bits [LANE_W*i+LANE_W-1 : LANE_W*i]
- out_err  out  1  beat carried an illegal mode
- out_valid  out  1  out_data/out_err valid
- out_ready  in  1  downstream accepts the beat

## Operation
- Notation: Ak is lane k of R1 and Bk is lane k of R2, with k = 0..H-1 and H = NLANE/2. P is the pass vector: lane i = Ai for i < H, and lane H+i = Bi.
- select 0, pass: out = P, so out_data = {R2, R1}.
- select 1, interleave: lane 2k = Ak, lane 2k+1 = Bk.
- select 2, broadcast: lane 2k = A0, lane 2k+1 = Bk.
- select 3, swap: lane i = Bi for i < H, lane H+i = Ai, so out_data = {R1, R2}.
- select 4, rotate: lane i = P[(i + rot) mod NLANE]. rot is an internal counter of width clog2(NLANE).
  - rot resets to 0.
  - rot increments by 1 on every accepted beat with select 4, wrapping from NLANE-1 to 0.
  - Beats in other modes leave rot unchanged.
  - The lanes of a beat are computed with rot's value before that beat's increment.
- select 5..7, illegal: out_data = 0, out_err = 1, rot unchanged. In all legal modes out_err = 0.
- Accept: a beat is accepted when enable && in_valid && in_ready.
- in_ready = enable && (!out_valid || out_ready), combinational.
- Output register:
  - On accept, load out_data and out_err, and set out_valid = 1.
  - If there is no accept and out_valid && out_ready, clear out_valid.
  - Otherwise hold.
- enable low: in_ready = 0. A pending output still drains if out_ready is high, but no new beat loads.
- Simultaneous drain and accept in the same cycle: the new beat replaces the old one and out_valid stays 1. Full throughput is 1 beat/cycle.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid = 0, out_data = 0, out_err = 0, rot = 0. in_ready follows its equation, so it equals enable while out_valid is 0.
- Latency: a beat accepted at edge n appears on out_data/out_valid after edge n and before edge n+1.
- While out_valid && !out_ready, out_data and out_err are stable, with no glitch across stalls.
- Reset asserted mid-stream: the pending output and rot are discarded immediately. The first beat after release starts with rot = 0.
- No combinational path from R1, R2, or select to the outputs. The only combinational path is out_ready/enable to in_ready.

## Test plan
- Reset then pass: R1 = 16, R2 = 15, select 0, out_ready = 1 -> the next cycle gives out_data = 0x0000000F_00000010, out_err = 0, out_valid = 1.
- Interleave/swap/broadcast: R1 = 16, R2 = 15, select 1 -> 0x00000000_00000F10. Select 3 -> 0x00000010_0000000F. Select 2 with R1 = 0x44332211, R2 = 0x88776655 -> 0x88117711_66115511.
- Rotate wrap: R1 = 0x44332211, R2 = 0x88776655, select 4, nine back-to-back beats.
  - Beat 0 gives 0x88776655_44332211.
  - Beat 1 gives 0x11887766_55443322.
  - Beat 8 equals beat 0.
  - A select 0 beat inserted mid-sequence does not advance rot.
- Backpressure: out_ready = 0 for 5 cycles while in_valid = 1 -> in_ready = 0 after the first accept, out_data is held stable, and no beats are lost or duplicated. On release, beats emerge in order at 1 per cycle.
- Illegal and enable: select 6 -> out_data = 0, out_err = 1, rot unchanged. With enable = 0 and in_valid = 1 -> in_ready = 0 and nothing loads, while the held output drains when out_ready = 1.
- Reset mid-operation: assert reset_n = 0 with out_valid = 1 and rot = 3 -> out_valid = 0 immediately. After release, a select 4 beat uses rot = 0.

Source files
------------

// File: rtl/steer_unit.sv
// Operand steering stage: splits two operands into lanes, routes them by mode
// (pass/interleave/broadcast/swap/rotate) and registers the result behind a valid/ready handshake.
module steer_unit #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [2:0]            select,
  input  logic [DATA_W-1:0]     R1,
  input  logic [DATA_W-1:0]     R2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NLANE = 2 * DATA_W / LANE_W;
  localparam int H     = NLANE / 2;
  localparam int ROT_W = (NLANE > 1) ? $clog2(NLANE) : 1;

  logic [2*DATA_W-1:0] pass_v;
  logic [2*DATA_W-1:0] steer_v;
  logic                illegal_v;
  logic                accept;

  logic [2*DATA_W-1:0] out_data_d,  out_data_q;
  logic                out_err_d,   out_err_q;
  logic                out_valid_d, out_valid_q;
  logic [ROT_W-1:0]    rot_d,       rot_q;

  // Source lane for rotate: (i + r) mod NLANE, valid for any NLANE, not just powers of two.
  function automatic int wrap_idx(input int i, input int r);
    int s;
    s = i + r;
    if (s >= NLANE) s = s - NLANE;
    return s;
  endfunction

  function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] r);
    if (r == ROT_W'(NLANE - 1)) return '0;
    return r + 1'b1;
  endfunction

  assign pass_v = {R2, R1};

  always_comb begin
    steer_v   = '0;
    illegal_v = 1'b0;
    case (select)
      3'd0: steer_v = pass_v;
      3'd1: begin
        for (int k = 0; k < H; k++) begin
          steer_v[(2*k)*LANE_W   +: LANE_W] = pass_v[k*LANE_W     +: LANE_W];
          steer_v[(2*k+1)*LANE_W +: LANE_W] = pass_v[(H+k)*LANE_W +: LANE_W];
        end
      end
      3'd2: begin
        for (int k = 0; k < H; k++) begin
          steer_v[(2*k)*LANE_W   +: LANE_W] = pass_v[0 +: LANE_W];
          steer_v[(2*k+1)*LANE_W +: LANE_W] = pass_v[(H+k)*LANE_W +: LANE_W];
        end
      end
      3'd3: steer_v = {R1, R2};
      3'd4: begin
        for (int i = 0; i < NLANE; i++)
          steer_v[i*LANE_W +: LANE_W] = pass_v[wrap_idx(i, int'(rot_q))*LANE_W +: LANE_W];
      end
      default: illegal_v = 1'b1;
    endcase
  end

  assign in_ready = enable && (!out_valid_q || out_ready);
  assign accept   = enable && in_valid && in_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    rot_d       = rot_q;
    if (accept) begin
      out_data_d  = steer_v;
      out_err_d   = illegal_v;
      out_valid_d = 1'b1;
      if (select == 3'd4) rot_d = rot_next(rot_q);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      rot_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      rot_q       <= rot_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule
